dmem_responder: RTL and testbench

- Data-side memory responder for the single-cycle MIPS core. It serves the core's data port (address, read enable, read data, write enable, write data, write strobe).
- Provides a byte-strobed word RAM plus a small MMIO block: 64-bit cycle counter, halt/tohost register, status register, sticky error capture.
- Reads are combinational, because the core consumes load data in the same cycle. Writes commit on the rising clock edge.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_ram.sv | 27 ++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets and address-decode type for dmem_responder
package dmem_pkg;

  localparam logic [7:0] OFF_CYCLE_LO = 8'h00;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h04;
  localparam logic [7:0] OFF_TOHOST   = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_LOADS    = 8'h10;
  localparam logic [7:0] OFF_STORES   = 8'h14;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_NONE
  } dec_e;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - byte-strobed word RAM, asynchronous read, synchronous write
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [3:0]                     strb_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Read returns the pre-write word, so a same-cycle store shows up next cycle.
  assign rdata_o = mem_q[addr_i];

  // Commit each enabled byte lane on the rising edge; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side RAM + MMIO responder; DMEM_PERF_EN adds load/store counters
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic        data_ren,
  output logic [31:0] data_rd,
  input  logic        data_wen,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wstrb,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [63:0] cycle_q, cycle_d;
  logic        halt_q, halt_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  dec_e        dec;
  logic [7:0]  off;
  logic        reg_known;
  logic [31:0] mmio_rdata;
  logic [31:0] ram_rdata;
  logic        acc_err;
  logic        ram_we;
  logic        tohost_wr;

  assign off = data_addr[7:0];

  // Classify the address into RAM, MMIO window or unmapped.
  always_comb begin
    dec = DEC_NONE;
    if ({1'b0, data_addr} < RAM_BYTES)               dec = DEC_RAM;
    else if (data_addr[31:8] == MMIO_BASE[31:8])     dec = DEC_MMIO;
  end

`ifdef DMEM_PERF_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;
`endif

  // MMIO register read mux; also flags which offsets are real registers.
  always_comb begin
    mmio_rdata = 32'h0;
    reg_known  = 1'b1;
    case (off)
      OFF_CYCLE_LO: mmio_rdata = cycle_q[31:0];
      OFF_CYCLE_HI: mmio_rdata = cycle_q[63:32];
      OFF_TOHOST:   mmio_rdata = 32'h0;
      OFF_STATUS:   mmio_rdata = {30'b0, err_q, halt_q};
`ifdef DMEM_PERF_EN
      OFF_LOADS:    mmio_rdata = loads_q;
      OFF_STORES:   mmio_rdata = stores_q;
`else
      OFF_LOADS:    mmio_rdata = 32'h0;
      OFF_STORES:   mmio_rdata = 32'h0;
`endif
      default:      reg_known  = 1'b0;
    endcase
  end

  // An erroring access has no side effects and loads back zero.
  assign acc_err = (data_ren || data_wen) &&
                   ((data_addr[1:0] != 2'b00) ||
                    (dec == DEC_NONE) ||
                    (dec == DEC_MMIO && !reg_known) ||
                    (data_wen && dec == DEC_MMIO && reg_known && off != OFF_TOHOST) ||
                    (data_ren && data_wen));

  assign ram_we    = data_wen && !acc_err && dec == DEC_RAM && !halt_q && rst_n;
  assign tohost_wr = data_wen && !acc_err && dec == DEC_MMIO && off == OFF_TOHOST &&
                     (data_wstrb != 4'b0000) && !halt_q;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .strb_i  (data_wstrb),
    .addr_i  (data_addr[AW+1:2]),
    .wdata_i (data_wr),
    .rdata_o (ram_rdata)
  );

  assign data_rd = (data_ren && !acc_err) ? ((dec == DEC_RAM) ? ram_rdata : mmio_rdata) : 32'h0;

  // Next state: free-running counter, first-writer-wins halt, first-fault error capture.
  always_comb begin
    cycle_d     = cycle_q + 64'd1;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (tohost_wr) begin
      halt_d      = 1'b1;
      halt_code_d = data_wr;
    end
    if (acc_err && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = data_addr;
    end
  end

  // Control/status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q     <= 64'd0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      cycle_q     <= cycle_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

`ifdef DMEM_PERF_EN
  // Count clean loads and effective stores (nonzero strobe, not suppressed by halt).
  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    if (data_ren && !acc_err) loads_d = loads_q + 32'd1;
    if (data_wen && !acc_err && !halt_q && data_wstrb != 4'b0000) stores_d = stores_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loads_q  <= 32'h0;
      stores_q <= 32'h0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
    end
  end
`endif

  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic        data_ren = 1'b0;
  logic [31:0] data_rd;
  logic        data_wen = 1'b0;
  logic [31:0] data_wr = 32'h0;
  logic [3:0]  data_wstrb = 4'h0;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;
  logic [31:0] err_addr;

  int tests_run = 0;
  int failed = 0;

  localparam logic [31:0] MB = 32'h1000_0000;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_addr  (data_addr),
    .data_ren   (data_ren),
    .data_rd    (data_rd),
    .data_wen   (data_wen),
    .data_wr    (data_wr),
    .data_wstrb (data_wstrb),
    .halt       (halt),
    .halt_code  (halt_code),
    .err        (err),
    .err_addr   (err_addr)
  );

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wr, input logic [3:0] strb);
    @(negedge clk);
    data_ren   = ren;
    data_wen   = wen;
    data_addr  = addr;
    data_wr    = wr;
    data_wstrb = strb;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    data_ren = 1'b0; data_wen = 1'b0; data_addr = 32'h0; data_wr = 32'h0; data_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (halt !== 1'b0) begin failed++; $display("FAIL reset_halt got %h exp 0", halt); end
    tests_run++; if (halt_code !== 32'h0) begin failed++; $display("FAIL reset_halt_code got %h exp 0", halt_code); end
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err got %h exp 0", err); end
    tests_run++; if (err_addr !== 32'h0) begin failed++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL idle_rd got %h exp 0", data_rd); end
    drive(1, 0, MB + 32'h0C, 0, 0);
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL reset_status got %h exp 0", data_rd); end
    // store during reset must be dropped
    drive(0, 1, 32'hC4, 32'h0000_0001, 4'hF);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; data_wen = 1'b1; data_addr = 32'hC4; data_wr = 32'hCAFE_F00D; data_wstrb = 4'hF;
    @(negedge clk);
    rst_n = 1'b1; data_wen = 1'b0;
    drive(1, 0, 32'hC4, 0, 0);
    tests_run++; if (data_rd !== 32'h1) begin failed++; $display("FAIL reset_store_drop got %h exp 00000001", data_rd); end
  endtask

  task automatic test_byte_strobe();
    drive(0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    drive(0, 1, 32'h40, 32'h1122_3344, 4'b0101);
    drive(1, 0, 32'h40, 0, 0);
    tests_run++; if (data_rd !== 32'hDE22_BE44) begin failed++; $display("FAIL strobe_merge got %h exp de22be44", data_rd); end
    drive(0, 1, 32'h40, 32'hFFFF_FFFF, 4'b0000);
    drive(1, 0, 32'h40, 0, 0);
    tests_run++; if (data_rd !== 32'hDE22_BE44) begin failed++; $display("FAIL strobe_zero got %h exp de22be44", data_rd); end
    drive(1, 0, 32'hFFC, 0, 0);
    drive(0, 1, 32'hFFC, 32'h0BAD_F00D, 4'hF);
    drive(1, 0, 32'hFFC, 0, 0);
    tests_run++; if (data_rd !== 32'h0BAD_F00D) begin failed++; $display("FAIL ram_top_word got %h exp 0badf00d", data_rd); end
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 32'h80, 32'h1234_5678, 4'hF);
    drive(1, 0, 32'h80, 0, 0);
    tests_run++; if (data_rd !== 32'h1234_5678) begin failed++; $display("FAIL old_value got %h exp 12345678", data_rd); end
    drive(0, 1, 32'h80, 32'hAAAA_AAAA, 4'hF);
    drive(1, 0, 32'h80, 0, 0);
    tests_run++; if (data_rd !== 32'hAAAA_AAAA) begin failed++; $display("FAIL new_value got %h exp aaaaaaaa", data_rd); end
  endtask

  task automatic test_cycle_counter();
    do_reset();
    repeat (9) @(negedge clk);
    drive(1, 0, MB + 32'h00, 0, 0);
    tests_run++; if (data_rd !== 32'h0000_000A) begin failed++; $display("FAIL cycle_lo_10 got %h exp 0000000a", data_rd); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    release dut.cycle_q;
    data_ren = 1'b1; data_addr = MB + 32'h00;
    #1;
    tests_run++; if (data_rd !== 32'hFFFF_FFFE) begin failed++; $display("FAIL wrap_lo_pre got %h exp fffffffe", data_rd); end
    drive(1, 0, MB + 32'h04, 0, 0);
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL wrap_hi_pre got %h exp 0", data_rd); end
    drive(1, 0, MB + 32'h04, 0, 0);
    tests_run++; if (data_rd !== 32'h1) begin failed++; $display("FAIL wrap_hi_post got %h exp 1", data_rd); end
    drive(1, 0, MB + 32'h00, 0, 0);
    tests_run++; if (data_rd !== 32'h1) begin failed++; $display("FAIL wrap_lo_post got %h exp 1", data_rd); end
  endtask

  task automatic test_errors();
    do_reset();
    drive(1, 0, 32'h42, 0, 0);
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL misaligned_rd got %h exp 0", data_rd); end
    drive(0, 1, 32'h2000_0000, 32'h5, 4'hF);
    tests_run++; if (err !== 1'b1) begin failed++; $display("FAIL err_set got %h exp 1", err); end
    tests_run++; if (err_addr !== 32'h42) begin failed++; $display("FAIL err_addr_first got %h exp 00000042", err_addr); end
    drive(1, 0, MB + 32'h0C, 0, 0);
    tests_run++; if (data_rd !== 32'h2) begin failed++; $display("FAIL status_err got %h exp 2", data_rd); end
    tests_run++; if (err_addr !== 32'h42) begin failed++; $display("FAIL err_addr_sticky got %h exp 00000042", err_addr); end
    drive(1, 1, 32'h80, 32'hBBBB_BBBB, 4'hF);
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL ren_wen_rd got %h exp 0", data_rd); end
    drive(1, 0, 32'h80, 0, 0);
    tests_run++; if (data_rd !== 32'hAAAA_AAAA) begin failed++; $display("FAIL ren_wen_nowrite got %h exp aaaaaaaa", data_rd); end
    drive(1, 0, MB + 32'h18, 0, 0);
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL mmio_hole_rd got %h exp 0", data_rd); end
  endtask

  task automatic test_tohost();
    do_reset();
    drive(0, 1, 32'h0, 32'h11, 4'hF);
    drive(0, 1, MB + 32'h08, 32'h5, 4'hF);
    drive(1, 0, MB + 32'h08, 0, 0);
    tests_run++; if (halt !== 1'b1) begin failed++; $display("FAIL halt_set got %h exp 1", halt); end
    tests_run++; if (halt_code !== 32'h5) begin failed++; $display("FAIL halt_code got %h exp 5", halt_code); end
    tests_run++; if (data_rd !== 32'h0) begin failed++; $display("FAIL tohost_read got %h exp 0", data_rd); end
    drive(0, 1, MB + 32'h08, 32'h9, 4'hF);
    drive(0, 1, 32'h0, 32'h77, 4'hF);
    drive(1, 0, 32'h0, 0, 0);
    tests_run++; if (data_rd !== 32'h11) begin failed++; $display("FAIL halt_ram_suppress got %h exp 00000011", data_rd); end
    tests_run++; if (halt_code !== 32'h5) begin failed++; $display("FAIL halt_first_wins got %h exp 5", halt_code); end
    drive(1, 0, MB + 32'h0C, 0, 0);
    tests_run++; if (data_rd !== 32'h1) begin failed++; $display("FAIL status_halt got %h exp 1", data_rd); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_loads;
    logic [31:0] exp_stores;
`ifdef DMEM_PERF_EN
    exp_loads = 32'd3; exp_stores = 32'd2;
`else
    exp_loads = 32'd0; exp_stores = 32'd0;
`endif
    do_reset();
    drive(1, 0, 32'h40, 0, 0);
    drive(1, 0, 32'h80, 0, 0);
    drive(0, 1, 32'h100, 32'h1, 4'hF);
    drive(1, 0, 32'h40, 0, 0);
    drive(0, 1, 32'h104, 32'h2, 4'h3);
    drive(0, 1, 32'h108, 32'h3, 4'h0);
    drive(1, 0, 32'h43, 0, 0);
    drive(1, 0, MB + 32'h10, 0, 0);
    tests_run++; if (data_rd !== exp_loads) begin failed++; $display("FAIL perf_loads got %h exp %h", data_rd, exp_loads); end
    drive(1, 0, MB + 32'h14, 0, 0);
    tests_run++; if (data_rd !== exp_stores) begin failed++; $display("FAIL perf_stores got %h exp %h", data_rd, exp_stores); end
    drive(0, 1, MB + 32'h10, 32'h0, 4'hF);
    drive(0, 0, 0, 0, 0);
    tests_run++; if (err_addr !== 32'h43) begin failed++; $display("FAIL perf_err_addr got %h exp 00000043", err_addr); end
  endtask

  initial begin
    test_reset();
    test_byte_strobe();
    test_same_cycle();
    test_cycle_counter();
    test_counter_wrap();
    test_errors();
    test_tohost();
    test_perf();
    drive(0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
